node_send_scheduler: RTL
========================

Name: node_send_scheduler

Overview:
- Shares the node's single interface-to-router send channel among NUM_PE processing elements, using round-robin arbitration.
- Accepts per-PE packet requests and drives the interface's send handshake (send request/ack, then data_valid words), stamping source, destination, sequence length and packet id on each packet.
- Returns one-cycle completion and error pulses to the granted PE.
- Sits inside the node, between the PE array and the interface module.

Parameters:
- NUM_PE, 4, number of requesting PEs (2..8)
- ACK_TIMEOUT, 255, max cycles in REQ waiting for if_send_ack before aborting (>=1)

Ports:
- N_clk  in  1  clock
- N_rst  in  1  asynchronous reset, active-high
- local_id  in  8  node id, driven onto if_src
- pe_req  in  NUM_PE  per-PE packet request, level, held until pe_done/pe_err
- pe_dst  in  8*NUM_PE  per-PE destination, slice i = [8i+7:8i]
- pe_len  in  6*NUM_PE  per-PE word count
- pe_data  in  32*NUM_PE  per-PE payload word
- pe_data_valid  in  NUM_PE  per-PE word valid
- pe_grant  out  NUM_PE  one-hot grant
- pe_data_ready  out  NUM_PE  word accept strobe to granted PE
- pe_done  out  NUM_PE  one-cycle pulse, packet sent
- pe_err  out  NUM_PE  one-cycle pulse, packet aborted
- if_send_req  out  1  send request to interface
- if_send_ack  in  1  interface acceptance
- if_data_valid  out  1  payload word valid
- if_data  out  32  payload word
- if_src  out  8  source id
- if_dst  out  8  destination
- if_seq_len  out  6  packet length in words
- if_id  out  6  packet id

Behaviour:
- Reset (async, immediate):
  - FSM=IDLE; all outputs 0.
  - RR pointer=NUM_PE-1, so PE0 has first priority.
  - Packet id counter=0; word counter=0; timeout counter=0.
- FSM states: IDLE, REQ, SEND, DONE.
- IDLE:
  - If any pe_req is set, select the first requester scanning from pointer+1 upward with wrap.
  - Latch grant index g, pe_dst[g] and pe_len[g]; assert pe_grant[g] (registered).
  - If latched len==0, go to DONE with error flag set. Otherwise go to REQ.
  - No request: stay in IDLE.
- REQ:
  - if_send_req=1.
  - if_src=local_id, if_dst, if_seq_len and if_id are driven from the latched values and are stable for the whole packet.
  - if_send_ack=1: next state SEND, word counter=0, if_send_req drops the next cycle.
  - Each cycle without ack increments the timeout counter.
  - Counter reaching ACK_TIMEOUT: go to DONE with error flag set.
- SEND:
  - pe_data_ready[g]=1, combinational from state and g. All other ready bits are 0.
  - Each cycle with pe_data_valid[g]=1 registers if_data<=pe_data[g] and if_data_valid<=1 (1-cycle latency), and increments the word counter.
  - Otherwise if_data_valid<=0; gaps are allowed.
  - The accepted word with counter==len-1 is the last: next state DONE.
  - pe_data_valid from non-granted PEs is ignored.
- DONE (one cycle):
  - Pulse pe_done[g], or pe_err[g] if the error flag is set.
  - Pointer<=g.
  - Packet id increments mod 64 on success only.
  - Deassert pe_grant and clear the error flag; go to IDLE.
  - The last if_data_valid of the packet coincides with this cycle.
- A requester must drop pe_req in the cycle after the pulse. If it is still high, it is re-arbitrated at lowest priority.
- pe_req dropping mid-packet is ignored; the packet completes.
- At most one pe_grant bit is set; pe_done/pe_err are never set together.
- if_send_req and if_data_valid are never high in the same cycle.
- Reset mid-packet: all outputs return to 0 asynchronously; no done/err pulse; the packet is abandoned.

Test Plan:
- Single packet: PE0 req with dst=0x07, len=3, local_id=0x02; ack 2 cycles after if_send_req → if_send_req high 3 cycles; if_src=0x02, if_dst=0x07, if_seq_len=3, if_id=0; 3 words appear on if_data 1 cycle after each PE0 valid; pe_done[0] pulses once; next packet carries if_id=1.
- Round-robin: PE0..PE3 all request continuously with len=1 and immediate ack → grant order 0,1,2,3,0; no PE is granted twice while another is waiting.
- Data gaps: len=4, PE valid pattern 1,0,0,1,1,0,1 → exactly 4 if_data_valid pulses carrying the words in order; done only after the 4th.
- Timeout: ACK_TIMEOUT=5, ack never asserted → if_send_req high 5 cycles; pe_err[g] pulses; no if_data_valid; if_id unchanged for the next packet.
- Zero length: pe_len=0 → no if_send_req; pe_err pulse within 2 cycles of the request; pointer advances past that PE.
- Async reset during SEND (after 2 of 5 words) → all outputs 0 in the same cycle; after release, PE0 has priority and if_id=0.

Source files
------------

// File: rtl/node_send_scheduler_if.sv
// Send channel between the node send scheduler and the router interface module.
// master = scheduler side, slave = interface module side.
interface node_send_scheduler_if;
    logic        if_send_req;
    logic        if_send_ack;
    logic        if_data_valid;
    logic [31:0] if_data;
    logic [7:0]  if_src;
    logic [7:0]  if_dst;
    logic [5:0]  if_seq_len;
    logic [5:0]  if_id;

    modport master (
        output if_send_req, if_data_valid, if_data, if_src, if_dst, if_seq_len, if_id,
        input  if_send_ack
    );

    modport slave (
        input  if_send_req, if_data_valid, if_data, if_src, if_dst, if_seq_len, if_id,
        output if_send_ack
    );
endinterface

// File: rtl/node_send_scheduler.sv
// Round-robin sharing of the node's single send channel among NUM_PE processing elements.
// Packets are stamped with source, destination, length and a success-only packet id.
module node_send_scheduler #(
    parameter int unsigned NUM_PE      = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                 N_clk,
    input  logic                 N_rst,
    input  logic [7:0]           local_id,
    input  logic [NUM_PE-1:0]    pe_req,
    input  logic [8*NUM_PE-1:0]  pe_dst,
    input  logic [6*NUM_PE-1:0]  pe_len,
    input  logic [32*NUM_PE-1:0] pe_data,
    input  logic [NUM_PE-1:0]    pe_data_valid,
    output logic [NUM_PE-1:0]    pe_grant,
    output logic [NUM_PE-1:0]    pe_data_ready,
    output logic [NUM_PE-1:0]    pe_done,
    output logic [NUM_PE-1:0]    pe_err,
    node_send_scheduler_if.master send_if
);
    localparam int unsigned IW = $clog2(NUM_PE);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;
    state_t state_q, state_d;

    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     g_q;
    logic [IW-1:0]     sel;
    logic              found;
    int unsigned       cand;
    logic [NUM_PE-1:0] grant_q;
    logic [7:0]        src_q;
    logic [7:0]        dst_q;
    logic [5:0]        len_q;
    logic [5:0]        id_q;
    logic [5:0]        wcnt_q;
    logic [TW-1:0]     tcnt_q;
    logic              err_q;
    logic [31:0]       data_q;
    logic              dv_q;
    logic              send_req;
    logic [5:0]        sel_len;
    logic              word_acc;
    logic              ack_timeout;

    assign sel_len     = pe_len[6*sel +: 6];
    assign word_acc    = (state_q == SEND) && pe_data_valid[g_q];
    assign ack_timeout = (tcnt_q == TW'(ACK_TIMEOUT - 1));

    // First requester strictly after the last served PE, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = 0;
        for (int unsigned i = 1; i <= NUM_PE; i++) begin
            cand = (32'(ptr_q) + i) % NUM_PE;
            if (!found && pe_req[cand[IW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        send_req      = 1'b0;
        pe_data_ready = '0;
        pe_done       = '0;
        pe_err        = '0;
        case (state_q)
            IDLE: if (found) state_d = (sel_len == '0) ? DONE : REQ;
            REQ: begin
                send_req = 1'b1;
                if (send_if.if_send_ack) state_d = SEND;
                else if (ack_timeout)    state_d = DONE;
            end
            SEND: begin
                pe_data_ready = grant_q;
                if (word_acc && (wcnt_q == len_q - 6'd1)) state_d = DONE;
            end
            DONE: begin
                if (err_q) pe_err  = grant_q;
                else       pe_done = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) begin
            ptr_q   <= IW'(NUM_PE - 1);
            g_q     <= '0;
            grant_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dv_q <= 1'b0;
                    if (found) begin
                        g_q     <= sel;
                        grant_q <= NUM_PE'(1) << sel;
                        src_q   <= local_id;
                        dst_q   <= pe_dst[8*sel +: 8];
                        len_q   <= sel_len;
                        err_q   <= (sel_len == '0);
                        tcnt_q  <= '0;
                    end
                end
                REQ: begin
                    dv_q <= 1'b0;
                    if (send_if.if_send_ack) begin
                        wcnt_q <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                        if (ack_timeout) err_q <= 1'b1;
                    end
                end
                SEND: begin
                    dv_q <= word_acc;
                    if (word_acc) begin
                        data_q <= pe_data[32*g_q +: 32];
                        wcnt_q <= wcnt_q + 6'd1;
                    end
                end
                DONE: begin
                    dv_q    <= 1'b0;
                    ptr_q   <= g_q;
                    grant_q <= '0;
                    err_q   <= 1'b0;
                    if (!err_q) id_q <= id_q + 6'd1;
                end
                default: dv_q <= 1'b0;
            endcase
        end
    end

    assign pe_grant              = grant_q;
    assign send_if.if_send_req   = send_req;
    assign send_if.if_data_valid = dv_q;
    assign send_if.if_data       = data_q;
    assign send_if.if_src        = src_q;
    assign send_if.if_dst        = dst_q;
    assign send_if.if_seq_len    = len_q;
    assign send_if.if_id         = id_q;
endmodule
